// File: rtl/sm4_tau_l.sv
// sm4_tau_l: SM4 T/T' transform - streams one word's bytes through a shared S-box,
// gathers the substituted bytes and applies L (round) or L' (key expansion).
module sm4_tau_l #(
    parameter int SBOX_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data,
    input  logic        i_mode,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_sbox_data,
    output logic        o_sbox_valid,
    input  logic [7:0]  i_sbox_data,
    input  logic        i_sbox_valid,
    output logic [31:0] o_t_data,
    output logic        o_t_valid,
    input  logic        i_t_ready,
    output logic        o_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;
    localparam int TW = $clog2(SBOX_TIMEOUT + 1);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] lin(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] lin_key(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [31:0]   a_q, a_d;
    logic          mode_q, mode_d;
    logic [1:0]    iss_q, iss_d;
    logic [1:0]    col_q, col_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   b_q, b_d;
    logic [7:0]    sbox_data_q, sbox_data_d;
    logic          sbox_valid_q, sbox_valid_d;
    logic [31:0]   t_data_q, t_data_d;
    logic          t_valid_q, t_valid_d;
    logic          err_q, err_d;
    logic          ready_q;

    logic [31:0] b_new;
    logic [31:0] c_new;
    logic [1:0]  iss_nx;
    logic        capture;
    logic        done;
    logic        timeout;

    // Byte slot is the complement of the counter: first arrival lands in B[31:24].
    always_comb begin
        b_new = b_q;
        b_new[{~col_q, 3'b000} +: 8] = i_sbox_data;
        c_new = mode_q ? lin_key(b_new) : lin(b_new);
        iss_nx = iss_q + 2'd1;
        capture = (state_q == S_ISSUE || state_q == S_COLLECT) && i_sbox_valid;
        done = capture && col_q == 2'd3;
        timeout = state_q == S_COLLECT && !done && to_q == TW'(SBOX_TIMEOUT - 1);
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        mode_d       = mode_q;
        iss_d        = iss_q;
        col_d        = col_q;
        to_d         = to_q;
        b_d          = b_q;
        sbox_data_d  = sbox_data_q;
        sbox_valid_d = sbox_valid_q;
        t_data_d     = t_data_q;
        t_valid_d    = t_valid_q;
        err_d        = err_q;
        if (state_q == S_IDLE) begin
            if (i_valid && ready_q) begin
                a_d          = i_data;
                mode_d       = i_mode;
                iss_d        = 2'd0;
                col_d        = 2'd0;
                to_d         = '0;
                sbox_valid_d = 1'b1;
                sbox_data_d  = i_data[31:24];
                state_d      = S_ISSUE;
            end
        end else if (state_q == S_ISSUE) begin
            if (iss_q == 2'd3) begin
                sbox_valid_d = 1'b0;
                to_d         = '0;
                state_d      = S_COLLECT;
            end else begin
                iss_d       = iss_nx;
                sbox_data_d = a_q[{~iss_nx, 3'b000} +: 8];
            end
        end else if (state_q == S_COLLECT) begin
            to_d = to_q + TW'(1);
            if (timeout) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end else if (i_t_ready) begin
            t_valid_d = 1'b0;
            state_d   = S_IDLE;
        end
        if (capture) begin
            b_d   = b_new;
            col_d = col_q + 2'd1;
        end
        if (done) begin
            t_data_d     = c_new;
            t_valid_d    = 1'b1;
            sbox_valid_d = 1'b0;
            state_d      = S_OUT;
        end
    end

    // Ready follows the next state, so it rises the cycle after a word leaves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            mode_q       <= 1'b0;
            iss_q        <= '0;
            col_q        <= '0;
            to_q         <= '0;
            b_q          <= '0;
            sbox_data_q  <= '0;
            sbox_valid_q <= 1'b0;
            t_data_q     <= '0;
            t_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            mode_q       <= mode_d;
            iss_q        <= iss_d;
            col_q        <= col_d;
            to_q         <= to_d;
            b_q          <= b_d;
            sbox_data_q  <= sbox_data_d;
            sbox_valid_q <= sbox_valid_d;
            t_data_q     <= t_data_d;
            t_valid_q    <= t_valid_d;
            err_q        <= err_d;
            ready_q      <= state_d == S_IDLE;
        end
    end

    assign o_ready      = ready_q;
    assign o_sbox_data  = sbox_data_q;
    assign o_sbox_valid = sbox_valid_q;
    assign o_t_data     = t_data_q;
    assign o_t_valid    = t_valid_q;
    assign o_err        = err_q;

endmodule
